// File: rtl/alu_pkg.sv
// Shared types for the two-requester ALU arbiter: opcodes, flag bundle and FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_e;

  // Packed MSB-first so the struct maps directly onto {Zero, Negative, Carry, Overflow}.
  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
  } alu_flags_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } arb_state_e;

endpackage

// File: rtl/alu_arb_grant.sv
// One-hot grant between two requesters; round-robin when ALU_ARB_RR_EN is defined,
// otherwise fixed priority with requester 0 winning.
module alu_arb_grant (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

`ifdef ALU_ARB_RR_EN
  always_comb begin
    grant = '0;
    if (req == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
    else              grant = req;
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant = '0;
    if (req[0])      grant = 2'b01;
    else if (req[1]) grant = 2'b10;
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one external ALU, one operation in flight at a time.
// Arbitration policy selected by ALU_ARB_RR_EN (round-robin) or fixed priority by default.
module alu_arbiter
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  input  logic [3:0]  req_op0,
  input  logic [3:0]  req_op1,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_carry,
  input  logic        alu_zero,
  input  logic        alu_negative,
  input  logic        alu_overflow
);

  arb_state_e  state, state_next;
  logic [1:0]  grant;
  logic        last_grant;
  logic        id;
  logic        accept;
  logic [31:0] a_q, b_q, result_q;
  logic [3:0]  op_q;
  alu_flags_t  flags_q;

  alu_arb_grant u_grant (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign req_ready = (state == ST_IDLE) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);

  always_comb begin
    state_next = state;
    rsp_valid  = '0;
    case (state)
      ST_IDLE: if (accept) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_RESP;
      ST_RESP: begin
        rsp_valid[id] = 1'b1;
        if (rsp_ready[id]) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= ALU_ADD;
      id         <= 1'b0;
      last_grant <= 1'b1;
      result_q   <= '0;
      flags_q    <= '0;
    end else begin
      if (state == ST_IDLE && accept) begin
        id   <= req_ready[1];
        a_q  <= req_ready[1] ? req_a1  : req_a0;
        b_q  <= req_ready[1] ? req_b1  : req_b0;
        op_q <= req_ready[1] ? req_op1 : req_op0;
`ifdef ALU_ARB_RR_EN
        last_grant <= req_ready[1];
`endif
      end
      if (state == ST_EXEC) begin
        result_q <= alu_result;
        flags_q  <= {alu_zero, alu_negative, alu_carry, alu_overflow};
      end
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign rsp_result = result_q;
  assign rsp_flags  = flags_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port req_valid, input, 2, per-requester request valid (bit i = requester i).
REQ-004 SHALL have port req_ready, output, 2, per-requester request accept.
REQ-005 SHALL have ports req_a0/req_b0, req_a1/req_b1, input, 32 each, signed operands of requester 0/1.
REQ-006 SHALL have ports req_op0, req_op1, input, 4 each, ALU opcode of requester 0/1.
REQ-007 SHALL have port rsp_valid, output, 2, per-requester response valid.
REQ-008 SHALL have port rsp_ready, input, 2, per-requester response accept.
REQ-009 SHALL have port rsp_result, output, 32, result shared by both requesters, qualified by rsp_valid.
REQ-010 SHALL have port rsp_flags, output, 4, {Zero, Negative, Carry, Overflow}, qualified by rsp_valid.
REQ-011 SHALL have ports alu_a, alu_b (output, 32) and alu_op (output, 4), driving the shared ALU.
REQ-012 SHALL have ports alu_result (input, 32) and alu_carry, alu_zero, alu_negative, alu_overflow (input, 1 each), from the shared ALU.

Function
REQ-013 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; one operation outstanding at a time.
REQ-014 In IDLE, req_ready SHALL be one-hot on the arbitration winner among set req_valid bits, else 2'b00; zero in EXEC and RESP.
REQ-015 On req_valid[i] & req_ready[i], SHALL capture operands, opcode and id i into operand registers and enter EXEC next cycle.
REQ-016 alu_a, alu_b, alu_op SHALL be driven from operand registers (registered, no combinational path from req_*).
REQ-017 In EXEC (exactly one cycle), SHALL register alu_result and flags into response registers and enter RESP.
REQ-018 In RESP, rsp_valid[id] SHALL be 1, other bit 0; result/flags SHALL hold stable until rsp_ready[id]=1, then enter IDLE.
REQ-019 rsp_ready on the non-owning bit SHALL be ignored; minimum latency accept-to-rsp_valid is 2 cycles; peak throughput one op per 3 cycles.
REQ-020 Opcodes SHALL pass unmodified; undefined opcodes produce whatever the ALU returns (0 for the team's ALU), no error.
REQ-021 Requesters SHALL hold req_valid and operands stable until accepted; arbiter does not latch unaccepted requests.
REQ-022 Arbitration per Configuration; last_grant register updates only on an accepted handshake.

Reset
REQ-023 rst SHALL force state IDLE, req_ready=0, rsp_valid=0, rsp_result=0, rsp_flags=0, alu_a=alu_b=0, alu_op=4'b0000, last_grant=1.
REQ-024 rst asserted in EXEC or RESP SHALL discard the in-flight operation with no response issued.

Configuration
REQ-025 Macro ALU_ARB_RR_EN defined: round-robin -- with both valid, grant requester != last_grant; single valid always wins.
REQ-026 Macro ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins when valid; last_grant unused.

Structure
REQ-027 Package alu_pkg SHALL hold alu_op_e (ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111), the flags struct and the FSM state enum.
REQ-028 Grant logic SHALL be sub-module alu_arb_grant (req[1:0], last_grant -> one-hot grant); the ALU itself stays external.

Verification
REQ-029 Req0 ADD a=5 b=7 alone -> req_ready=01, two cycles later rsp_valid=01, result=12, flags=0000.
REQ-030 Req1 SUB a=3 b=3 -> result=0, flags Z=1 C=1 N=0 V=0 on rsp_valid=10.
REQ-031 Both valid continuously, RR_EN on -> grants 0,1,0,1 alternating; RR_EN off -> grants 0,0,0.
REQ-032 Req0 ADD 0x7FFFFFFF+1, rsp_ready held low 5 cycles -> rsp_valid stays 01, result=0x80000000, N=1 V=1 stable, req_ready=00 throughout.
REQ-033 rst pulsed during RESP -> rsp_valid=00 immediately, IDLE next, no response delivered; next request served normally.
REQ-034 rsp_ready=10 while rsp_valid=01 -> no state change; response retained.
